mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, data width of RAM words and requester data buses.
REQ-002 Parameter RAM_ADDR_BITS, default 16, width of all address buses.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous active-low reset; sampled on rising clk edge, asserted when 0.
REQ-005 cpu_req  input  1  CPU data-port request; held high until cpu_ack.
REQ-006 cpu_we  input  1  1 = store, 0 = load; qualified by cpu_req.
REQ-007 cpu_adr  input  RAM_ADDR_BITS  CPU word address.
REQ-008 cpu_wdata  input  WIDTH  CPU store data.
REQ-009 cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-010 cpu_rdata  output  WIDTH  CPU load data, valid only while cpu_ack=1.
REQ-011 io_req, io_we, io_adr, io_wdata, io_ack, io_rdata: identical to the cpu_* ports above, for the game-I/O requester (player-input / display side).
REQ-012 mem_en  output  1  RAM enable.
REQ-013 mem_write  output  1  RAM write strobe.
REQ-014 mem_read  output  1  RAM read strobe.
REQ-015 mem_adr  output  RAM_ADDR_BITS  RAM address.
REQ-016 mem_wdata  output  WIDTH  RAM write data.
REQ-017 mem_rdata  input  WIDTH  RAM read data; RAM is clocked, data valid one cycle after a read strobe.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states: IDLE, ISSUE, CAPTURE; encoding is free.
REQ-020 IDLE: if any req=1, arbitrate (REQ-024/REQ-025), latch owner, we, adr and wdata of the winner, go to ISSUE; otherwise stay in IDLE.
REQ-021 ISSUE (one cycle): mem_en=1, mem_write=latched we, mem_read=!latched we, mem_adr/mem_wdata=latched values; all mem_* outputs are registered; then go to CAPTURE.
REQ-022 CAPTURE (one cycle): owner's ack=1 and owner's rdata=mem_rdata (combinational pass-through); non-owner ack=0; mem_en=mem_write=mem_read=0.
REQ-023 CAPTURE exit: if the non-owner's req=1, grant it and go directly to ISSUE; otherwise go to IDLE; the owner's own req is ignored during CAPTURE.
REQ-024 Latency: req sampled high in IDLE at cycle N gives ISSUE at N+1 and ack at N+2; alternating requesters sustain one access per 2 cycles; the same requester gets at most one access per 3 cycles.
REQ-025 Tie-break when both req=1 at arbitration: see Configuration.
REQ-026 Request fields are latched at grant; changes to adr/wdata/we after grant do not affect the access in flight.
REQ-027 A req deasserted after grant (protocol violation) does not abort the access; the access completes and ack is still pulsed.
REQ-028 At most one ack is high in any cycle; ack is never high outside CAPTURE.
REQ-029 rdata outputs are 0 whenever the corresponding ack=0.
REQ-030 Writes and reads are treated identically for arbitration and timing; a write is committed at the clk edge that ends ISSUE.

Reset
REQ-031 When reset=0 at a clk edge: state goes to IDLE; mem_en, mem_write, mem_read go to 0; mem_adr and mem_wdata go to 0; last_owner goes to IO, so the CPU wins the first tie.
REQ-032 Reset asserted during ISSUE does not cancel the RAM operation already presented on that edge; no ack is issued for it.
REQ-033 Reset asserted during CAPTURE: ack is still high in that cycle; the FSM returns to IDLE and no new grant is made.

Configuration
REQ-034 Macro ARB_ROUND_ROBIN_EN defined: on a tie, grant the requester that is not last_owner; last_owner updates on every grant.
REQ-035 Macro ARB_ROUND_ROBIN_EN undefined: on a tie, the CPU always wins; the last_owner register is not implemented.

Verification
REQ-036 Reset: hold reset=0 for 2 cycles, then release with no req -> mem_en=0, busy=0, cpu_ack=io_ack=0.
REQ-037 CPU store, then load: cpu_req=1, we=1, adr=0x0010, wdata=0xBEEF -> mem_write=1 at N+1 and cpu_ack at N+2; next, a load from 0x0010 -> cpu_rdata=0xBEEF while cpu_ack=1.
REQ-038 Simultaneous req from reset: both requesters load -> CPU acked at N+2, IO issued at N+3 and acked at N+4. With ARB_ROUND_ROBIN_EN, the next tie goes to the CPU; without it, all ties go to the CPU.
REQ-039 Field change after grant: change cpu_adr from 0x0005 to 0x0006 during ISSUE -> mem_adr stays 0x0005.
REQ-040 Reset during ISSUE of an IO write to 0x0020 with 0x1234 -> the RAM holds 0x1234, io_ack is never pulsed, and the state is IDLE on the next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (CPU / game-I/O) arbiter onto a single clocked RAM; ARB_ROUND_ROBIN_EN selects round-robin tie-break.
// Latency: req seen in IDLE -> registered RAM strobe next cycle -> ack (with read data) the cycle after.
// Backpressure: requesters hold req until their one-cycle ack; the loser of a tie waits and is granted from CAPTURE.
module mem_arbiter #(
    parameter int WIDTH         = 16,
    parameter int RAM_ADDR_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [RAM_ADDR_BITS-1:0] cpu_adr,
    input  logic [WIDTH-1:0]         cpu_wdata,
    output logic                     cpu_ack,
    output logic [WIDTH-1:0]         cpu_rdata,
    input  logic                     io_req,
    input  logic                     io_we,
    input  logic [RAM_ADDR_BITS-1:0] io_adr,
    input  logic [WIDTH-1:0]         io_wdata,
    output logic                     io_ack,
    output logic [WIDTH-1:0]         io_rdata,
    output logic                     mem_en,
    output logic                     mem_write,
    output logic                     mem_read,
    output logic [RAM_ADDR_BITS-1:0] mem_adr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t                     state, state_nxt;
    logic                       owner_io;
    logic                       grant, grant_io;
    logic                       tie_to_io;
    logic                       sel_we;
    logic [RAM_ADDR_BITS-1:0]   sel_adr;
    logic [WIDTH-1:0]           sel_wdata;

    // owner_io holds the most recent grant, so it also serves as last_owner.
`ifdef ARB_ROUND_ROBIN_EN
    assign tie_to_io = !owner_io;
`else
    assign tie_to_io = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_io  = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || io_req) begin
                    grant     = 1'b1;
                    grant_io  = io_req && (!cpu_req || tie_to_io);
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                // Only the non-owner may be granted back-to-back.
                grant     = owner_io ? cpu_req : io_req;
                grant_io  = !owner_io;
                state_nxt = grant ? ISSUE : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (!reset) begin
            state_nxt = IDLE;
            grant     = 1'b0;
            grant_io  = 1'b0;
        end
    end

    assign sel_we    = grant_io ? io_we    : cpu_we;
    assign sel_adr   = grant_io ? io_adr   : cpu_adr;
    assign sel_wdata = grant_io ? io_wdata : cpu_wdata;

    // RAM strobes are registered at grant, so they are live exactly during ISSUE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_en    <= 1'b0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            owner_io  <= 1'b1;
        end else begin
            mem_en    <= grant;
            mem_write <= grant && sel_we;
            mem_read  <= grant && !sel_we;
            if (grant) begin
                owner_io  <= grant_io;
                mem_adr   <= sel_adr;
                mem_wdata <= sel_wdata;
            end
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        cpu_ack   = 1'b0;
        io_ack    = 1'b0;
        cpu_rdata = '0;
        io_rdata  = '0;
        if (state == CAPTURE) begin
            if (owner_io) begin
                io_ack   = 1'b1;
                io_rdata = mem_rdata;
            end else begin
                cpu_ack   = 1'b1;
                cpu_rdata = mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a read-first clocked RAM model behind it.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, io_req, io_we;
    logic [15:0] cpu_adr, cpu_wdata, io_adr, io_wdata;
    logic        cpu_ack, io_ack;
    logic [15:0] cpu_rdata, io_rdata;
    logic        mem_en, mem_write, mem_read;
    logic [15:0] mem_adr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.WIDTH(16), .RAM_ADDR_BITS(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_adr(io_adr), .io_wdata(io_wdata),
        .io_ack(io_ack), .io_rdata(io_rdata),
        .mem_en(mem_en), .mem_write(mem_write), .mem_read(mem_read),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten RAM words read as 0x1000 + address so every load returns a distinct value.
    logic [15:0]  ram [0:255];
    logic [255:0] written = '0;

    function automatic logic [15:0] ram_word(input logic [7:0] a);
        return written[a] ? ram[a] : (16'h1000 + {8'h00, a});
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= ram_word(mem_adr[7:0]);
            if (mem_write) begin
                ram[mem_adr[7:0]]     <= mem_wdata;
                written[mem_adr[7:0]] <= 1'b1;
            end
        end
    end

    typedef struct {
        logic        rst;
        logic        creq, cwe;
        logic [15:0] cadr, cwd;
        logic        ireq, iwe;
        logic [15:0] iadr, iwd;
        logic        busy, en, wr, rd;
        logic [15:0] madr;
        logic        cack, iack;
        logic [15:0] crd, ird;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic creq, input logic cwe, input logic [15:0] cadr, input logic [15:0] cwd,
        input logic ireq, input logic iwe, input logic [15:0] iadr, input logic [15:0] iwd,
        input logic b, input logic en, input logic wr, input logic rd, input logic [15:0] madr,
        input logic cack, input logic iack, input logic [15:0] crd, input logic [15:0] ird);
        vec_t v;
        v.rst = rst; v.creq = creq; v.cwe = cwe; v.cadr = cadr; v.cwd = cwd;
        v.ireq = ireq; v.iwe = iwe; v.iadr = iadr; v.iwd = iwd;
        v.busy = b; v.en = en; v.wr = wr; v.rd = rd; v.madr = madr;
        v.cack = cack; v.iack = iack; v.crd = crd; v.ird = ird;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        reset = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_wdata = '0;
        io_req = 0;  io_we = 0;  io_adr = '0;  io_wdata = '0;

        //                rst creq we cadr   cwd      ireq we iadr  iwd      busy en wr rd madr    cack iack crd      ird
        vecs.push_back(mk(0,  0,0,16'h0, 16'h0,     0,0,16'h0, 16'h0,   0,0,0,0,16'h0,   0,0,16'h0,    16'h0));
        vecs.push_back(mk(0,  0,0,16'h0, 16'h0,     0,0,16'h0, 16'h0,   0,0,0,0,16'h0,   0,0,16'h0,    16'h0));
        vecs.push_back(mk(1,  0,0,16'h0, 16'h0,     0,0,16'h0, 16'h0,   0,0,0,0,16'h0,   0,0,16'h0,    16'h0));
        // Tie from reset: CPU first, IO follows directly out of CAPTURE.
        vecs.push_back(mk(1,  1,0,16'h10,16'h0,     1,0,16'h11,16'h0,   1,1,0,1,16'h10,  0,0,16'h0,    16'h0));
        vecs.push_back(mk(1,  1,0,16'h10,16'h0,     1,0,16'h11,16'h0,   1,0,0,0,16'h10,  1,0,16'h1010, 16'h0));
        vecs.push_back(mk(1,  0,0,16'h10,16'h0,     1,0,16'h11,16'h0,   1,1,0,1,16'h11,  0,0,16'h0,    16'h0));
        vecs.push_back(mk(1,  0,0,16'h10,16'h0,     1,0,16'h11,16'h0,   1,0,0,0,16'h11,  0,1,16'h0,    16'h1011));
        // Owner's own req is ignored in CAPTURE.
        vecs.push_back(mk(1,  0,0,16'h10,16'h0,     1,0,16'h11,16'h0,   0,0,0,0,16'h11,  0,0,16'h0,    16'h0));
        // Second tie goes to the CPU again.
        vecs.push_back(mk(1,  1,0,16'h12,16'h0,     1,0,16'h13,16'h0,   1,1,0,1,16'h12,  0,0,16'h0,    16'h0));
        vecs.push_back(mk(1,  1,0,16'h12,16'h0,     1,0,16'h13,16'h0,   1,0,0,0,16'h12,  1,0,16'h1012, 16'h0));
        vecs.push_back(mk(1,  0,0,16'h12,16'h0,     1,0,16'h13,16'h0,   1,1,0,1,16'h13,  0,0,16'h0,    16'h0));
        vecs.push_back(mk(1,  0,0,16'h12,16'h0,     1,0,16'h13,16'h0,   1,0,0,0,16'h13,  0,1,16'h0,    16'h1013));
        vecs.push_back(mk(1,  0,0,16'h0, 16'h0,     0,0,16'h0, 16'h0,   0,0,0,0,16'h13,  0,0,16'h0,    16'h0));
        // CPU store 0xBEEF to 0x10 (read-first RAM returns old word), then load it back.
        vecs.push_back(mk(1,  1,1,16'h10,16'hBEEF,  0,0,16'h0, 16'h0,   1,1,1,0,16'h10,  0,0,16'h0,    16'h0));
        vecs.push_back(mk(1,  1,1,16'h10,16'hBEEF,  0,0,16'h0, 16'h0,   1,0,0,0,16'h10,  1,0,16'h1010, 16'h0));
        vecs.push_back(mk(1,  1,0,16'h10,16'h0,     0,0,16'h0, 16'h0,   0,0,0,0,16'h10,  0,0,16'h0,    16'h0));
        vecs.push_back(mk(1,  1,0,16'h10,16'h0,     0,0,16'h0, 16'h0,   1,1,0,1,16'h10,  0,0,16'h0,    16'h0));
        vecs.push_back(mk(1,  1,0,16'h10,16'h0,     0,0,16'h0, 16'h0,   1,0,0,0,16'h10,  1,0,16'hBEEF, 16'h0));
        vecs.push_back(mk(1,  0,0,16'h0, 16'h0,     0,0,16'h0, 16'h0,   0,0,0,0,16'h10,  0,0,16'h0,    16'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe; cpu_adr = vecs[i].cadr; cpu_wdata = vecs[i].cwd;
            io_req = vecs[i].ireq;  io_we = vecs[i].iwe;  io_adr = vecs[i].iadr;  io_wdata = vecs[i].iwd;
            step();
            check($sformatf("r%0d_busy", i),      busy,      vecs[i].busy);
            check($sformatf("r%0d_mem_en", i),    mem_en,    vecs[i].en);
            check($sformatf("r%0d_mem_write", i), mem_write, vecs[i].wr);
            check($sformatf("r%0d_mem_read", i),  mem_read,  vecs[i].rd);
            check($sformatf("r%0d_mem_adr", i),   mem_adr,   vecs[i].madr);
            check($sformatf("r%0d_cpu_ack", i),   cpu_ack,   vecs[i].cack);
            check($sformatf("r%0d_io_ack", i),    io_ack,    vecs[i].iack);
            check($sformatf("r%0d_cpu_rdata", i), cpu_rdata, vecs[i].crd);
            check($sformatf("r%0d_io_rdata", i),  io_rdata,  vecs[i].ird);
        end

        // Address change after grant does not affect the access in flight.
        cpu_req = 1; cpu_we = 0; cpu_adr = 16'h0005;
        step();
        check("adrchg_issue_adr", mem_adr, 16'h0005);
        cpu_adr = 16'h0006;
        step();
        check("adrchg_capture_adr", mem_adr, 16'h0005);
        check("adrchg_ack", cpu_ack, 1'b1);
        check("adrchg_rdata", cpu_rdata, 16'h1005);
        cpu_req = 0;
        step();
        check("adrchg_idle", busy, 1'b0);

        // Req dropped after grant: the access still completes with an ack.
        io_req = 1; io_we = 0; io_adr = 16'h0007;
        step();
        check("drop_issue_en", mem_en, 1'b1);
        io_req = 0;
        step();
        check("drop_ack", io_ack, 1'b1);
        check("drop_rdata", io_rdata, 16'h1007);
        step();
        check("drop_idle", busy, 1'b0);

        // Reset during ISSUE of an IO write: write lands, no ack, back to IDLE.
        io_req = 1; io_we = 1; io_adr = 16'h0020; io_wdata = 16'h1234;
        step();
        check("rstiss_write", mem_write, 1'b1);
        check("rstiss_wdata", mem_wdata, 16'h1234);
        reset = 0;
        step();
        check("rstiss_busy", busy, 1'b0);
        check("rstiss_ack", io_ack, 1'b0);
        check("rstiss_en", mem_en, 1'b0);
        reset = 1; io_req = 0; io_we = 0;
        step();
        check("rstiss_ack2", io_ack, 1'b0);
        check("rstiss_ram", ram_word(8'h20), 16'h1234);
        cpu_req = 1; cpu_we = 0; cpu_adr = 16'h0020;
        step();
        step();
        check("rstiss_readback", cpu_rdata, 16'h1234);
        cpu_req = 0;
        step();

        // Reset during CAPTURE: ack still shown, no grant to the waiting IO.
        cpu_req = 1; cpu_we = 0; cpu_adr = 16'h0012;
        step();
        io_req = 1; io_we = 0; io_adr = 16'h0013;
        step();
        reset = 0;
        #1;
        check("rstcap_ack", cpu_ack, 1'b1);
        check("rstcap_rdata", cpu_rdata, 16'h1012);
        step();
        check("rstcap_busy", busy, 1'b0);
        check("rstcap_en", mem_en, 1'b0);
        check("rstcap_io_ack", io_ack, 1'b0);
        reset = 1; cpu_req = 0; io_req = 0;
        step();
        check("rstcap_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
